ipic_lite_responder: RTL and testbench
======================================

# ipic_lite_responder

Target-side counterpart of the lite IPIC master in the AXI TDMA ath9k middleware. It accepts single-beat read and write commands on the IPIC master request and qualifier signals and answers them with the IPIC status and data signals. Requests are served from a local bank of 32-bit registers with a configurable number of wait states. It serves two roles: the on-chip target for TDMA control and status words, and a cycle-accurate bus model for verifying IPIC initiators.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_NATIVE_DATA_WIDTH, 32, data width; only 32 is supported.
- C_REG_ADDR_BITS, 4, log2 of the register count (16 words).
- C_BASE_ADDR, 32'h4000_0000, bank base; low C_REG_ADDR_BITS+2 bits are zero.
- C_WAIT_STATES, 2, wait cycles between cmdack and the data beat; range 0..15.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ip2bus_mstrd_req  in  1  read request.
- ip2bus_mstwr_req  in  1  write request.
- ip2bus_mst_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- ip2bus_mst_be  in  C_NATIVE_DATA_WIDTH/8  byte enables.
- ip2bus_mst_lock  in  1  ignored.
- ip2bus_mst_reset  in  1  synchronous command abort.
- ip2bus_mstwr_d  in  C_NATIVE_DATA_WIDTH  write data.
- bus2ip_mst_cmdack  out  1  command accepted, one-cycle pulse.
- bus2ip_mst_cmplt  out  1  command complete, one-cycle pulse.
- bus2ip_mst_error  out  1  valid only with cmplt.
- bus2ip_mst_rearbitrate  out  1  constant 0.
- bus2ip_mst_cmd_timeout  out  1  constant 0.
- bus2ip_mstrd_d  out  C_NATIVE_DATA_WIDTH  read data; held until the next read is accepted.
- bus2ip_mstrd_src_rdy_n  out  1  read beat valid, active low.
- bus2ip_mstwr_dst_rdy_n  out  1  write beat taken, active low.
- reg_wr_pulse  out  1  a register was written this cycle.
- reg_wr_index  out  C_REG_ADDR_BITS  index of the written register.
- reg_wr_data  out  32  new register value after the merge.
- usr_rd_index  in  C_REG_ADDR_BITS  local readback index.
- usr_rd_data  out  32  register at usr_rd_index, one cycle later.

## Operation
- States: IDLE, ACK, WAIT, BEAT, CMPLT, DRAIN.
- IDLE: when either request is high, capture addr, be, wr_d and type, then go to ACK.
- ACK: cmdack=1 for one cycle. Go to WAIT if C_WAIT_STATES>0, otherwise to BEAT.
- WAIT: a 4-bit counter counts C_WAIT_STATES cycles, then goes to BEAT.
- BEAT, read: src_rdy_n=0 and mstrd_d=reg[index].
- BEAT, write: dst_rdy_n=0; reg[index] and the reg_wr_* outputs update.
- CMPLT: cmplt=1 for one cycle, with error as decoded.
- DRAIN: wait until both requests are low, then return to IDLE. This prevents a held request from being accepted twice.
- Decode: index = addr[C_REG_ADDR_BITS+1:2].
- Error conditions:
  - addr[1:0]!=0;
  - upper address bits differ from C_BASE_ADDR;
  - both requests high in the same cycle.
- Error handling: the BEAT state is skipped (ACK/WAIT goes straight to CMPLT), no register is written, mstrd_d=0, and error=1 with cmplt.
- ip2bus_mst_reset=1 in any state: go to IDLE next cycle and drive all strobes to their idle level. Register contents are kept. The aborted command produces no cmplt.
- Reset values:
  - state IDLE;
  - cmdack, cmplt, error, reg_wr_pulse = 0;
  - src_rdy_n, dst_rdy_n = 1;
  - mstrd_d, reg_wr_index, reg_wr_data, usr_rd_data = 0;
  - all registers 0.

## Timing
- Request sampled high in IDLE at cycle T.
- cmdack at T+1.
- Data beat at T+2+W, where W = C_WAIT_STATES.
- cmplt at T+3+W; with an error, cmplt at T+2+W.
- Next acceptance is possible no earlier than T+5+W (after DRAIN sees both requests low); T+4+W on an error.
- Local readback against a bus write in the same cycle: usr_rd_data shows the old value that cycle and the new value one cycle later.
- reset_n assertion clears state immediately, mid-command included; no pending cmplt is emitted.

## Configuration
- IPIC_RESP_BE_EN defined: writes merge per byte lane according to ip2bus_mst_be. be=0 leaves the register unchanged but still produces the beat, reg_wr_pulse and cmplt.
- Undefined: be is ignored and writes replace the full word.

## Test plan
- Write 0xDEADBEEF to 0x4000_0008, then read it back with W=2 → cmdack at T+1, dst_rdy_n low at T+4, reg_wr_index=2, cmplt at T+5, error=0; the read returns 0xDEADBEEF at its beat and holds it after cmplt.
- Read from 0x5000_0000, and separately read from 0x4000_0002 → cmdack, then cmplt with error=1 at T+2+W; no src_rdy_n beat; mstrd_d=0.
- Rd and wr requests high together → single cmdack, cmplt with error=1, no register change.
- With IPIC_RESP_BE_EN: write 0xFFFFFFFF, then write 0x00000000 with be=4'b0101 → register reads 0xFF00FF00. Without the macro → 0x00000000.
- Request held high for 20 cycles → exactly one cmdack/cmplt pair; the second cmdack only after the request drops and rises again.
- ip2bus_mst_reset pulsed during WAIT, and separately reset_n pulsed during WAIT → no cmplt; IDLE next cycle; earlier register contents kept for mst_reset and zeroed for reset_n.

Source files
------------

// File: rtl/ipic_lite_responder_if.sv
// ipic_lite_responder_if: IPIC lite master request/qualifier and target status/data bundle.
interface ipic_lite_responder_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ip2bus_mstrd_req;
  logic          ip2bus_mstwr_req;
  logic [AW-1:0] ip2bus_mst_addr;
  logic [DW/8-1:0] ip2bus_mst_be;
  logic          ip2bus_mst_lock;
  logic          ip2bus_mst_reset;
  logic [DW-1:0] ip2bus_mstwr_d;
  logic          bus2ip_mst_cmdack;
  logic          bus2ip_mst_cmplt;
  logic          bus2ip_mst_error;
  logic          bus2ip_mst_rearbitrate;
  logic          bus2ip_mst_cmd_timeout;
  logic [DW-1:0] bus2ip_mstrd_d;
  logic          bus2ip_mstrd_src_rdy_n;
  logic          bus2ip_mstwr_dst_rdy_n;
  modport master (
    output ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
           ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
    input  bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mst_rearbitrate,
           bus2ip_mst_cmd_timeout, bus2ip_mstrd_d, bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );
  modport slave (
    input  ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
           ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
    output bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mst_rearbitrate,
           bus2ip_mst_cmd_timeout, bus2ip_mstrd_d, bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );
endinterface

// File: rtl/ipic_lite_responder.sv
// ipic_lite_responder: single-beat IPIC target backed by a bank of 32-bit registers.
// Define IPIC_RESP_BE_EN to merge writes per byte lane; otherwise writes replace the word.
module ipic_lite_responder #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_NATIVE_DATA_WIDTH = 32,
  parameter int C_REG_ADDR_BITS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 'h4000_0000,
  parameter int C_WAIT_STATES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  ipic_lite_responder_if.slave       bus,
  output logic                       reg_wr_pulse,
  output logic [C_REG_ADDR_BITS-1:0] reg_wr_index,
  output logic [31:0]                reg_wr_data,
  input  logic [C_REG_ADDR_BITS-1:0] usr_rd_index,
  output logic [31:0]                usr_rd_data
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int RB = C_REG_ADDR_BITS;
  localparam int NR = 1 << RB;
  localparam logic [3:0] WL = 4'(C_WAIT_STATES == 0 ? 0 : C_WAIT_STATES - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ACK = 3'd1, S_WAIT = 3'd2,
                         S_BEAT = 3'd3, S_CMPLT = 3'd4, S_DRAIN = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RB-1:0] idx_q, idx_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [31:0]   regs_q [NR];
  logic [31:0]   regs_d [NR];
  logic          pulse_q, pulse_d;
  logic [RB-1:0] widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   usr_q, usr_d;
  logic [31:0]   merged;
  logic          rd_req, wr_req, abort, enter_beat;
  logic          unused_bits;
  assign rd_req = bus.ip2bus_mstrd_req;
  assign wr_req = bus.ip2bus_mstwr_req;
  assign abort  = bus.ip2bus_mst_reset;
  assign unused_bits = ^{bus.ip2bus_mst_lock, be_q};
`ifdef IPIC_RESP_BE_EN
  always_comb begin
    merged = regs_q[idx_q];
    for (int i = 0; i < 4; i++) if (be_q[i]) merged[8*i +: 8] = wdat_q[8*i +: 8];
  end
`else
  assign merged = wdat_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    regs_d  = regs_q;
    pulse_d = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    usr_d   = regs_q[usr_rd_index];
    if (abort) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE:
          if (rd_req || wr_req) begin
            state_d = S_ACK;
            idx_d   = bus.ip2bus_mst_addr[RB+1:2];
            be_d    = bus.ip2bus_mst_be;
            wdat_d  = bus.ip2bus_mstwr_d;
            wr_d    = wr_req && !rd_req;
            err_d   = bus.ip2bus_mst_addr[1:0] != 2'b00 ||
                      bus.ip2bus_mst_addr[AW-1:RB+2] != C_BASE_ADDR[AW-1:RB+2] ||
                      (rd_req && wr_req);
            rdat_d  = rd_req ? 32'd0 : rdat_q;
          end
        S_ACK: begin
          cnt_d   = 4'd0;
          state_d = C_WAIT_STATES > 0 ? S_WAIT : err_q ? S_CMPLT : S_BEAT;
        end
        S_WAIT:
          if (cnt_q == WL) state_d = err_q ? S_CMPLT : S_BEAT;
          else cnt_d = cnt_q + 4'd1;
        S_BEAT:  state_d = S_CMPLT;
        S_CMPLT: state_d = S_DRAIN;
        S_DRAIN: state_d = (rd_req || wr_req) ? S_DRAIN : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    // register side effects land on the edge that enters BEAT, so they align with the beat strobe
    enter_beat = state_d == S_BEAT && state_q != S_BEAT;
    if (enter_beat && wr_q) begin
      regs_d[idx_q] = merged;
      pulse_d       = 1'b1;
      widx_d        = idx_q;
      wdata_d       = merged;
    end
    if (enter_beat && !wr_q) rdat_d = regs_q[idx_q];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      regs_q  <= '{default: '0};
      pulse_q <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      usr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      usr_q   <= usr_d;
    end
  assign bus.bus2ip_mst_cmdack      = state_q == S_ACK && !abort;
  assign bus.bus2ip_mst_cmplt       = state_q == S_CMPLT && !abort;
  assign bus.bus2ip_mst_error       = state_q == S_CMPLT && !abort && err_q;
  assign bus.bus2ip_mst_rearbitrate = 1'b0;
  assign bus.bus2ip_mst_cmd_timeout = 1'b0;
  assign bus.bus2ip_mstrd_d         = rdat_q;
  assign bus.bus2ip_mstrd_src_rdy_n = !(state_q == S_BEAT && !wr_q && !abort);
  assign bus.bus2ip_mstwr_dst_rdy_n = !(state_q == S_BEAT && wr_q && !abort);
  assign reg_wr_pulse = pulse_q;
  assign reg_wr_index = widx_q;
  assign reg_wr_data  = wdata_q;
  assign usr_rd_data  = usr_q;
endmodule

// File: tb/tb_ipic_lite_responder.sv
// tb_ipic_lite_responder: directed table, corner sequences and randomized traffic against a register-map model.
module tb_ipic_lite_responder;
  localparam int W = 2;
  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef IPIC_RESP_BE_EN
  localparam logic [31:0] BEEXP = 32'hFF00FF00;
`else
  localparam logic [31:0] BEEXP = 32'h0000_0000;
`endif
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rdv;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic        reg_wr_pulse;
  logic [3:0]  reg_wr_index;
  logic [31:0] reg_wr_data;
  logic [3:0]  usr_rd_index = '0;
  logic [31:0] usr_rd_data;
  logic [31:0] mregs [16];
  int passed = 0, total = 0;
  vec_t tv [12];
  ipic_lite_responder_if b ();
  ipic_lite_responder #(.C_WAIT_STATES(W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b),
    .reg_wr_pulse(reg_wr_pulse), .reg_wr_index(reg_wr_index), .reg_wr_data(reg_wr_data),
    .usr_rd_index(usr_rd_index), .usr_rd_data(usr_rd_data)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic bit model_err(input bit rd, input bit wr, input logic [31:0] a);
    return (a % 4 != 0) || ((a >> 6) != (BASE >> 6)) || (rd && wr);
  endfunction
  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
`ifdef IPIC_RESP_BE_EN
    logic [31:0] m = 0;
    for (int i = 0; i < 4; i++) m |= be[i] ? (32'hFF << (8*i)) : 32'h0;
    return (old & ~m) | (wd & m);
`else
    return wd;
`endif
  endfunction
  task automatic idle_bus();
    b.ip2bus_mstrd_req = 0; b.ip2bus_mstwr_req = 0; b.ip2bus_mst_addr = 0;
    b.ip2bus_mst_be = 0; b.ip2bus_mst_lock = 0; b.ip2bus_mst_reset = 0; b.ip2bus_mstwr_d = 0;
  endtask
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input bit eerr, input logic [31:0] erd, input string nm);
    int ack_k = -1, beat_k = -1, cm_k = -1;
    logic err = 0, pulse = 0;
    logic [31:0] rdat = 0, hold = 0, usr_b = 0, usr_a = 0, wdat = 0;
    logic [3:0] widx = 0;
    logic [31:0] eold = mregs[a[5:2]];
    logic [31:0] enew = model_merge(eold, wd, be);
    @(negedge clk);
    b.ip2bus_mstrd_req = rd; b.ip2bus_mstwr_req = wr; b.ip2bus_mst_addr = a;
    b.ip2bus_mst_be = be; b.ip2bus_mstwr_d = wd; usr_rd_index = a[5:2];
    for (int k = 1; k <= 30 && cm_k < 0; k++) begin
      @(negedge clk);
      if (b.bus2ip_mst_cmdack) begin
        if (ack_k < 0) ack_k = k;
        b.ip2bus_mstrd_req = 0; b.ip2bus_mstwr_req = 0;
      end
      if (!b.bus2ip_mstrd_src_rdy_n || !b.bus2ip_mstwr_dst_rdy_n) begin
        beat_k = k; rdat = b.bus2ip_mstrd_d; usr_b = usr_rd_data;
        pulse = reg_wr_pulse; widx = reg_wr_index; wdat = reg_wr_data;
      end
      if (b.bus2ip_mst_cmplt) begin
        cm_k = k; err = b.bus2ip_mst_error; hold = b.bus2ip_mstrd_d; usr_a = usr_rd_data;
      end
    end
    idle_bus();
    chk({nm, " cmdack_cycle"}, ack_k, 1);
    chk({nm, " cmplt_cycle"}, cm_k, eerr ? 2 + W : 3 + W);
    chk({nm, " error"}, {31'd0, err}, {31'd0, eerr});
    chk({nm, " beat_cycle"}, beat_k, eerr ? -1 : 2 + W);
    if (rd && !eerr) begin
      chk({nm, " rd_beat_data"}, rdat, erd);
      chk({nm, " rd_hold_data"}, hold, erd);
    end
    if (rd && eerr) chk({nm, " rd_err_data"}, hold, 32'd0);
    if (wr && !rd && !eerr) begin
      chk({nm, " wr_pulse"}, {31'd0, pulse}, 32'd1);
      chk({nm, " wr_index"}, {28'd0, widx}, {28'd0, a[5:2]});
      chk({nm, " wr_data"}, wdat, enew);
      chk({nm, " usr_old"}, usr_b, eold);
      chk({nm, " usr_new"}, usr_a, enew);
      mregs[a[5:2]] = enew;
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic usr_check(input logic [3:0] i);
    usr_rd_index = i;
    @(negedge clk);
    chk($sformatf("usr_rd[%0d]", i), usr_rd_data, mregs[i]);
  endtask
  task automatic start_wait_abort(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    b.ip2bus_mstwr_req = 1; b.ip2bus_mst_addr = a; b.ip2bus_mst_be = 4'hF; b.ip2bus_mstwr_d = wd;
    @(negedge clk);
    chk("abort_seq cmdack", {31'd0, b.bus2ip_mst_cmdack}, 32'd1);
    b.ip2bus_mstwr_req = 0;
    @(negedge clk);
  endtask
  task automatic count_quiet(input string nm);
    int cm = 0, bt = 0;
    repeat (8) begin
      @(negedge clk);
      cm += b.bus2ip_mst_cmplt;
      bt += !b.bus2ip_mstwr_dst_rdy_n;
    end
    chk({nm, " no_cmplt"}, cm, 0);
    chk({nm, " no_beat"}, bt, 0);
  endtask
  initial begin
    int acks, cms;
    bit seen;
    idle_bus();
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    tv[0]  = '{1'b0, 1'b1, 32'h4000_0008, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b0, 32'h4000_0008, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tv[2]  = '{1'b1, 1'b0, 32'h5000_0000, 4'hF, 32'h0,         1'b1, 32'h0};
    tv[3]  = '{1'b1, 1'b0, 32'h4000_0002, 4'hF, 32'h0,         1'b1, 32'h0};
    tv[4]  = '{1'b1, 1'b1, 32'h4000_0008, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
    tv[5]  = '{1'b1, 1'b0, 32'h4000_0008, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tv[6]  = '{1'b0, 1'b1, 32'h4000_000C, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tv[7]  = '{1'b0, 1'b1, 32'h4000_000C, 4'h5, 32'h0,         1'b0, 32'h0};
    tv[8]  = '{1'b1, 1'b0, 32'h4000_000C, 4'hF, 32'h0,         1'b0, BEEXP};
    tv[9]  = '{1'b0, 1'b1, 32'h4000_0040, 4'hF, 32'h1111_2222, 1'b1, 32'h0};
    tv[10] = '{1'b0, 1'b1, 32'h4000_003C, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0};
    tv[11] = '{1'b1, 1'b0, 32'h4000_003C, 4'hF, 32'h0,         1'b0, 32'h0BAD_F00D};
    repeat (3) @(negedge clk);
    chk("rst cmdack", {31'd0, b.bus2ip_mst_cmdack}, 32'd0);
    chk("rst cmplt", {31'd0, b.bus2ip_mst_cmplt}, 32'd0);
    chk("rst error", {31'd0, b.bus2ip_mst_error}, 32'd0);
    chk("rst src_rdy_n", {31'd0, b.bus2ip_mstrd_src_rdy_n}, 32'd1);
    chk("rst dst_rdy_n", {31'd0, b.bus2ip_mstwr_dst_rdy_n}, 32'd1);
    chk("rst mstrd_d", b.bus2ip_mstrd_d, 32'd0);
    chk("rst reg_wr_pulse", {31'd0, reg_wr_pulse}, 32'd0);
    chk("rst reg_wr_data", reg_wr_data, 32'd0);
    chk("rst usr_rd_data", usr_rd_data, 32'd0);
    chk("rearbitrate", {31'd0, b.bus2ip_mst_rearbitrate}, 32'd0);
    chk("cmd_timeout", {31'd0, b.bus2ip_mst_cmd_timeout}, 32'd0);
    reset_n = 1;
    for (int i = 0; i < 12; i++)
      issue(tv[i].rd, tv[i].wr, tv[i].a, tv[i].be, tv[i].wd, tv[i].err, tv[i].rdv, $sformatf("vec%0d", i));
    acks = 0; cms = 0;
    @(negedge clk);
    b.ip2bus_mstrd_req = 1; b.ip2bus_mst_addr = 32'h4000_0008;
    repeat (20) begin
      @(negedge clk);
      acks += b.bus2ip_mst_cmdack;
      cms += b.bus2ip_mst_cmplt;
    end
    chk("held acks", acks, 1);
    chk("held cmplts", cms, 1);
    b.ip2bus_mstrd_req = 0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      acks += b.bus2ip_mst_cmdack;
    end
    chk("dropped acks", acks, 0);
    b.ip2bus_mstrd_req = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = b.bus2ip_mst_cmdack;
    end
    chk("rerise ack", {31'd0, seen}, 32'd1);
    b.ip2bus_mstrd_req = 0;
    repeat (8) @(negedge clk);
    issue(0, 1, 32'h4000_0014, 4'hF, 32'hA5A5_0001, 0, 0, "pre_abort");
    start_wait_abort(32'h4000_0014, 32'h5A5A_0002);
    b.ip2bus_mst_reset = 1;
    @(negedge clk);
    b.ip2bus_mst_reset = 0;
    count_quiet("mst_reset");
    issue(1, 0, 32'h4000_0014, 4'hF, 0, 0, 32'hA5A5_0001, "after_mst_reset");
    start_wait_abort(32'h4000_0014, 32'h5A5A_0003);
    reset_n = 0;
    #1;
    chk("rst_n async cmplt", {31'd0, b.bus2ip_mst_cmplt}, 32'd0);
    chk("rst_n async dst_rdy_n", {31'd0, b.bus2ip_mstwr_dst_rdy_n}, 32'd1);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    count_quiet("reset_n");
    issue(1, 0, 32'h4000_0014, 4'hF, 0, 0, 32'h0, "after_reset_n");
    issue(1, 0, 32'h4000_0008, 4'hF, 0, 0, 32'h0, "after_reset_n2");
    for (int n = 0; n < 80; n++) begin
      int kind = $urandom_range(0, 7), r = $urandom_range(0, 15);
      logic [31:0] a = BASE + ($urandom_range(0, 15) << 2);
      bit rd = (r == 0) || (r < 8), wr = (r == 0) || (r >= 8);
      if (kind == 0) a = a + $urandom_range(1, 3);
      if (kind == 1) a = a ^ (32'h1 << $urandom_range(6, 31));
      issue(rd, wr, a, 4'($urandom), $urandom, model_err(rd, wr, a), mregs[a[5:2]], $sformatf("rnd%0d", n));
      usr_check(4'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
